// File: rtl/lfsr_pkg.sv
// Shared types and default widths for the LFSR keystream XOR stage.
package lfsr_pkg;

   // Datapath stage state: gather keystream, wait for plaintext, present ciphertext
   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_KEY  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam int LFSR_N_DEF = 4;
   localparam int WORD_W_DEF = 8;

   // Width of a counter that must reach the value w inclusive
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/lfsr_keystream_xor_if.sv
// Plaintext-in / ciphertext-out valid/ready bus of the keystream XOR stage.
interface lfsr_keystream_xor_if #(parameter int W = lfsr_pkg::WORD_W_DEF);

   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;

   modport master (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid
   );

   modport slave (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_valid
   );

endinterface

// File: rtl/keystream_packer.sv
// LSB-first keystream packer: each captured bit enters at the MSB and the
// word shifts right, so after W captures the k-th captured bit sits at bit k.
module keystream_packer
   import lfsr_pkg::*;
#(
   parameter  int W  = WORD_W_DEF,
   localparam int CW = cnt_width(W)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         cap,
   input  logic         bit_in,
   output logic [W-1:0] word,
   output logic         full,
   output logic         last
);

   logic [W-1:0]  word_r;
   logic [CW-1:0] count_r;

   // Shift register and bit counter; clear wins over capture
   always_ff @(posedge clk) begin
      if (rst) begin
         word_r  <= {W{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (clr) begin
         word_r  <= {W{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (cap) begin
         word_r  <= {bit_in, word_r[W-1:1]};
         count_r <= count_r + CW'(1);
      end
   end

   assign word = word_r;
   assign full = (count_r == CW'(W));
   assign last = (count_r == CW'(W - 1));

endmodule

// File: rtl/lfsr_keystream_xor.sv
// Stream-cipher datapath stage: drives the LFSR enable, packs one LFSR bit
// per enabled cycle into a W-bit keystream word and XORs each word with one
// plaintext word. Optional build macro KEYSTREAM_PREFETCH_EN keeps filling
// the next keystream word while ciphertext waits in HOLD.
module lfsr_keystream_xor
   import lfsr_pkg::*;
#(
   parameter int n = LFSR_N_DEF,
   parameter int W = WORD_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [n-1:0]          random,
   output logic                  lfsr_ena,
   input  logic                  resync,
   lfsr_keystream_xor_if.slave   bus
);

   state_t       state_r;
   state_t       state_nxt_s;
   logic         init_r;
   logic [W-1:0] dout_r;
   logic         dout_valid_r;
   logic [W-1:0] keystream_s;
   logic         full_s;
   logic         last_s;
   logic         cap_s;
   logic         clr_s;
   logic         load_s;
   logic         release_s;
   logic         din_ready_s;
   logic         unused_random_s;

   // Only random[0] is consumed; the upper state bits are deliberately ignored
   assign unused_random_s = ^random;

   keystream_packer #(.W(W)) u_packer (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr_s),
      .cap    (cap_s),
      .bit_in (random[0]),
      .word   (keystream_s),
      .full   (full_s),
      .last   (last_s)
   );

   // Next-state, capture and handshake decode; resync beats any same-cycle din handshake
   always_comb begin
      state_nxt_s = state_r;
      cap_s       = 1'b0;
      clr_s       = 1'b0;
      load_s      = 1'b0;
      release_s   = 1'b0;
      din_ready_s = 1'b0;
      case (state_r)
         ST_FILL: begin
            if (resync) begin
               clr_s = 1'b1;
            end else if (init_r) begin
               cap_s = 1'b0;          // first cycle after reset captures nothing
            end else if (full_s) begin
               state_nxt_s = ST_KEY;
            end else begin
               cap_s = 1'b1;
               if (last_s) begin
                  state_nxt_s = ST_KEY;
               end else begin
                  state_nxt_s = ST_FILL;
               end
            end
         end
         ST_KEY: begin
            if (resync) begin
               clr_s       = 1'b1;
               state_nxt_s = ST_FILL;
            end else begin
               din_ready_s = 1'b1;
               if (bus.din_valid) begin
                  load_s      = 1'b1;
                  clr_s       = 1'b1;   // word consumed; packer restarts at bit 0
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_KEY;
               end
            end
         end
         ST_HOLD: begin
`ifdef KEYSTREAM_PREFETCH_EN
            if (resync) begin
               clr_s = 1'b1;
            end else if (!full_s) begin
               cap_s = 1'b1;
            end else begin
               cap_s = 1'b0;
            end
            if (bus.dout_ready) begin
               release_s = 1'b1;
               if (!resync && (full_s || last_s)) begin
                  state_nxt_s = ST_KEY;
               end else begin
                  state_nxt_s = ST_FILL;
               end
            end else begin
               state_nxt_s = ST_HOLD;
            end
`else
            if (bus.dout_ready) begin
               release_s   = 1'b1;
               state_nxt_s = ST_FILL;
            end else begin
               state_nxt_s = ST_HOLD;
            end
`endif
         end
         default: begin
            clr_s       = 1'b1;
            state_nxt_s = ST_FILL;
         end
      endcase
   end

   // State, start-up flag and registered ciphertext; rst overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_FILL;
         init_r       <= 1'b1;
         dout_r       <= {W{1'b0}};
         dout_valid_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         init_r  <= 1'b0;
         if (load_s) begin
            dout_r       <= bus.din ^ keystream_s;
            dout_valid_r <= 1'b1;
         end else if (release_s) begin
            dout_valid_r <= 1'b0;
         end
      end
   end

   assign lfsr_ena       = cap_s & ~rst;
   assign bus.din_ready  = din_ready_s & ~rst;
   assign bus.dout       = dout_r;
   assign bus.dout_valid = dout_valid_r;

endmodule

// File: tb/tb_lfsr_keystream_xor.sv
// Self-checking bench for lfsr_keystream_xor with an attached 4-bit LFSR
// (reset state 0001) and a reference keystream built from the bit sequence.
module tb_lfsr_keystream_xor;
   import lfsr_pkg::*;

   localparam int N = 4;
   localparam int W = 8;
`ifdef KEYSTREAM_PREFETCH_EN
   localparam int PF = 1;
`else
   localparam int PF = 0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         resync;
   logic [N-1:0] lfsr_r;
   logic [N-1:0] random;
   logic         lfsr_ena;

   int  checks = 0;
   int  errors = 0;
   int  p;
   bit  seq [15];
   logic [W-1:0] exp_q[$];

   lfsr_keystream_xor_if #(.W(W)) bus ();

   lfsr_keystream_xor #(.n(N), .W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .random   (random),
      .lfsr_ena (lfsr_ena),
      .resync   (resync),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Attached Fibonacci LFSR, advancing only when enabled
   always_ff @(posedge clk) begin
      if (rst) lfsr_r <= 4'b0001;
      else if (lfsr_ena) lfsr_r <= {lfsr_r[2:0], lfsr_r[3] ^ lfsr_r[0]};
   end
   assign random = lfsr_r;

   // Keystream word made of global LFSR output bits pos..pos+7, LSB first
   function automatic logic [W-1:0] ks_at(input int pos);
      logic [W-1:0] r;
      for (int k = 0; k < W; k++) r[k] = seq[(pos + k) % 15];
      return r;
   endfunction

   // LFSR bits expected to be captured during a HOLD of 'stall' waiting cycles plus the release cycle
   function automatic int hold_caps(input int stall);
      return (PF == 1) ? ((stall + 1 < W) ? stall + 1 : W) : 0;
   endfunction

   task automatic do_reset();
      rst = 1'b1; resync = 1'b0;
      bus.din = 8'h00; bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0; p = 0; exp_q.delete();
   endtask

   // Offer one plaintext word; returns the ciphertext seen the cycle after the handshake
   task automatic send_din(input logic [W-1:0] d, input bit rnd_rdy, output logic [W-1:0] got,
                           output logic gotv, output int ena_cnt, output int wait_cyc);
      bus.din = d; bus.din_valid = 1'b1;
      bus.dout_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
      ena_cnt = 0; wait_cyc = 0;
      #1;
      while (bus.din_ready !== 1'b1 && wait_cyc < 40) begin
         if (lfsr_ena === 1'b1) ena_cnt++;
         @(negedge clk);
         if (rnd_rdy) bus.dout_ready = 1'($urandom_range(0, 1));
         #1;
         wait_cyc++;
      end
      if (wait_cyc >= 40) begin
         errors++; $display("FAIL din_ready_timeout: got no din_ready, required within 40 cycles");
      end
      @(negedge clk);
      bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
      got = bus.dout; gotv = bus.dout_valid;
   endtask

   task automatic release_dout();
      bus.dout_ready = 1'b1;
      @(negedge clk);
      bus.dout_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; resync = 1'b0; bus.din_valid = 1'b1; bus.din = 8'h5A; bus.dout_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid: got %b required 0", bus.dout_valid); end
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h required 00", bus.dout); end
      checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL rst_din_ready: got %b required 0", bus.din_ready); end
      checks++; if (lfsr_ena !== 1'b0) begin errors++; $display("FAIL rst_lfsr_ena: got %b required 0", lfsr_ena); end
      rst = 1'b0; p = 0;
      #1;
      checks++; if (lfsr_ena !== 1'b0) begin errors++; $display("FAIL first_cycle_lfsr_ena: got %b required 0", lfsr_ena); end
   endtask

   task automatic test_first_words();
      logic [W-1:0] got, d; logic gotv; int ec, wc;
      send_din(8'h00, 1'b0, got, gotv, ec, wc);
      checks++; if (ec !== W) begin errors++; $display("FAIL fill_ena_count: got %0d required %0d", ec, W); end
      checks++; if (wc !== W + 1) begin errors++; $display("FAIL fill_latency: got %0d required %0d", wc, W + 1); end
      checks++; if (gotv !== 1'b1) begin errors++; $display("FAIL word1_valid: got %b required 1", gotv); end
      checks++; if (got !== 8'hAF) begin errors++; $display("FAIL word1_dout: got %h required af", got); end
      release_dout(); p = 8;
      send_din(8'hFF, 1'b0, got, gotv, ec, wc);
      checks++; if (ec !== W - hold_caps(0)) begin errors++; $display("FAIL word2_ena_count: got %0d required %0d", ec, W - hold_caps(0)); end
      checks++; if (got !== 8'h76) begin errors++; $display("FAIL word2_dout: got %h required 76", got); end
      release_dout(); p = 16;
      d = 8'($urandom);
      send_din(d, 1'b0, got, gotv, ec, wc);
      checks++; if (got !== (d ^ ks_at(p))) begin errors++; $display("FAIL word3_dout: got %h required %h", got, d ^ ks_at(p)); end
      release_dout(); p += 8;
   endtask

   task automatic test_hold_stall();
      logic [W-1:0] got, d, e; logic gotv; int ec, wc;
      do_reset();
      d = 8'($urandom); e = d ^ ks_at(p); p += 8;
      send_din(d, 1'b0, got, gotv, ec, wc);
      checks++; if (got !== e) begin errors++; $display("FAIL hold_word: got %h required %h", got, e); end
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (bus.dout !== e || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL hold_stable: got %h/%b required %h/1", bus.dout, bus.dout_valid, e); end
         checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL hold_din_ready: got %b required 0", bus.din_ready); end
         checks++; if (lfsr_ena !== 1'(PF)) begin errors++; $display("FAIL hold_lfsr_ena: got %b required %0d", lfsr_ena, PF); end
         @(negedge clk);
      end
      release_dout();
      d = 8'($urandom); e = d ^ ks_at(p); p += 8;
      send_din(d, 1'b0, got, gotv, ec, wc);
      checks++; if (wc !== W - hold_caps(5)) begin errors++; $display("FAIL after_hold_latency: got %0d required %0d", wc, W - hold_caps(5)); end
      checks++; if (got !== e) begin errors++; $display("FAIL after_hold_dout: got %h required %h", got, e); end
      release_dout();
   endtask

   task automatic test_resync();
      logic [W-1:0] got, d, e; logic gotv; int ec, wc, nw;
      do_reset();
      repeat (4) @(negedge clk);           // cycles 1..3 after release captured bits
      resync = 1'b1; #1;
      checks++; if (lfsr_ena !== 1'b0) begin errors++; $display("FAIL resync_no_capture: got %b required 0", lfsr_ena); end
      @(negedge clk); resync = 1'b0; p = 3;
      d = 8'($urandom); e = d ^ ks_at(p); p += 8;
      send_din(d, 1'b0, got, gotv, ec, wc);
      checks++; if (ec !== W) begin errors++; $display("FAIL resync_ena_count: got %0d required %0d", ec, W); end
      checks++; if (got !== e) begin errors++; $display("FAIL resync_fill_dout: got %h required %h", got, e); end
      release_dout();
      nw = 0; #1;
      while (bus.din_ready !== 1'b1 && nw < 40) begin @(negedge clk); #1; nw++; end
      checks++; if (nw >= 40) begin errors++; $display("FAIL key_wait_timeout: got no din_ready, required within 40 cycles"); end
      p += 8;                              // word gathered for KEY is discarded below
      bus.din = 8'hC3; bus.din_valid = 1'b1; resync = 1'b1; #1;
      checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL resync_key_din_ready: got %b required 0", bus.din_ready); end
      @(negedge clk); resync = 1'b0; bus.din_valid = 1'b0; #1;
      checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL resync_key_no_dout: got %b required 0", bus.dout_valid); end
      d = 8'($urandom); e = d ^ ks_at(p); p += 8;
      send_din(d, 1'b0, got, gotv, ec, wc);
      checks++; if (got !== e) begin errors++; $display("FAIL resync_key_dout: got %h required %h", got, e); end
      release_dout();
   endtask

   task automatic test_rst_in_hold();
      logic [W-1:0] got, d, e; logic gotv; int ec, wc;
      do_reset();
      d = 8'($urandom);
      send_din(d, 1'b0, got, gotv, ec, wc);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.dout_valid !== 1'b0 || bus.dout !== 8'h00) begin errors++; $display("FAIL rst_hold_dout: got %h/%b required 00/0", bus.dout, bus.dout_valid); end
      checks++; if (bus.din_ready !== 1'b0 || lfsr_ena !== 1'b0) begin errors++; $display("FAIL rst_hold_ctrl: got %b/%b required 0/0", bus.din_ready, lfsr_ena); end
      rst = 1'b0; p = 0;
      d = 8'($urandom); e = d ^ ks_at(p); p += 8;
      send_din(d, 1'b0, got, gotv, ec, wc);
      checks++; if (ec !== W || wc !== W + 1) begin errors++; $display("FAIL rst_hold_refill: got %0d/%0d required %0d/%0d", ec, wc, W, W + 1); end
      checks++; if (got !== e) begin errors++; $display("FAIL rst_hold_dout2: got %h required %h", got, e); end
      release_dout();
   endtask

   task automatic test_random();
      logic [W-1:0] got, d, e; logic gotv; int ec, wc, stall;
      do_reset();
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 3)) begin
            bus.dout_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         d = 8'($urandom);
         exp_q.push_back(d ^ ks_at(p)); p += 8;
         send_din(d, 1'b1, got, gotv, ec, wc);
         e = exp_q.pop_front();
         checks++; if (gotv !== 1'b1 || got !== e) begin errors++; $display("FAIL rand_word %0d: got %h/%b required %h/1", i, got, gotv, e); end
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) begin
            @(negedge clk); #1;
            checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== e) begin errors++; $display("FAIL rand_hold %0d: got %h/%b required %h/1", i, bus.dout, bus.dout_valid, e); end
         end
         release_dout(); #1;
         checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rand_release %0d: got %b required 0", i, bus.dout_valid); end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_queue: got %0d left required 0", exp_q.size()); end
   endtask

   // Overall time bound so the run always ends
   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int st;
      st = 1;
      for (int i = 0; i < 15; i++) begin
         seq[i] = st[0];
         st = ((st << 1) | (((st >> 3) ^ st) & 1)) & 15;
      end
      test_reset();
      test_first_words();
      test_hold_stall();
      test_resync();
      test_rst_in_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
